// File: rtl/vga_sprite_pkg.sv
// rtl/vga_sprite_pkg.sv - VGA timing constants and sprite slot record shared by the sprite path
package vga_sprite_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_ACTIVE    = 480;
    localparam int V_TOTAL     = 525;
    localparam int COMMIT_LINE = 480;

    // Slot select / image index width (clog2 of the slot count)
    localparam int SEL_W = 2;

    typedef struct packed {
        logic             en;
        logic [9:0]       x;
        logic [9:0]       y;
        logic [SEL_W-1:0] img;
    } sprite_cfg_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// rtl/sprite_hit_unit.sv - per-slot coverage test and texel offsets for one lookahead pixel
module sprite_hit_unit
    import vga_sprite_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int COL_W = $clog2(SPR_W),
    parameter int ROW_W = $clog2(SPR_H)
) (
    input  logic [10:0]      px,
    input  logic [10:0]      vy,
    input  sprite_cfg_t      cfg,
    output logic             hit,
    output logic [COL_W-1:0] col_off,
    output logic [ROW_W-1:0] row_off
);

    // 11-bit bounds so x+SPR_W never wraps; parts beyond the active area are clipped
    logic [10:0] x_lo;
    logic [10:0] x_hi;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        on_screen;
    logic        in_x;
    logic        in_y;

    assign x_lo = {1'b0, cfg.x};
    assign y_lo = {1'b0, cfg.y};
    assign x_hi = x_lo + 11'(SPR_W);
    assign y_hi = y_lo + 11'(SPR_H);

    assign on_screen = (px < 11'(H_ACTIVE)) && (vy < 11'(V_ACTIVE));
    assign in_x      = (px >= x_lo) && (px < x_hi);
    assign in_y      = (vy >= y_lo) && (vy < y_hi);
    assign hit       = cfg.en && on_screen && in_x && in_y;

    // Offsets are only meaningful when hit is set; low bits suffice for power-of-2 sprites
    assign dx      = px - x_lo;
    assign dy      = vy - y_lo;
    assign col_off = dx[COL_W-1:0];
    assign row_off = dy[ROW_W-1:0];

endmodule

// File: rtl/sprite_pixel_scheduler.sv
// rtl/sprite_pixel_scheduler.sv - shares one sprite ROM across slots and drives the VGA pixel path
module sprite_pixel_scheduler
    import vga_sprite_pkg::*;
#(
    parameter int         NUM_SPR     = 4,
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter int         ADDR_W      = 12,
    parameter logic [5:0] TRANSPARENT = 6'b110011,
    parameter int         LOOKAHEAD   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hor_count,
    input  logic [9:0]        ver_count,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic              cfg_en,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic [SEL_W-1:0]  cfg_img,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [5:0]        rom_data,
    output logic              draw,
    output logic [5:0]        rgb_out,
    output logic              frame_tick
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    sprite_cfg_t pending_q [NUM_SPR];
    sprite_cfg_t active_q  [NUM_SPR];

    logic              commit;
    logic [10:0]       px_sum;
    logic [10:0]       px;
    logic [10:0]       vy;
    logic [NUM_SPR-1:0] hit_vec;
    logic [COL_W-1:0]  col_off [NUM_SPR];
    logic [ROW_W-1:0]  row_off [NUM_SPR];
    logic              hit_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              s1_hit_q;
    logic              s2_hit_q;
    logic              draw_d;
    logic              draw_q;
    logic [5:0]        rgb_d;
    logic [5:0]        rgb_q;

    // Commit slot: first column of the first blanking line, when no lookahead pixel is visible
    assign commit     = (hor_count == 10'd0) && (ver_count == 10'(COMMIT_LINE));
    assign cfg_ready  = reset || !commit;
    assign frame_tick = commit && !reset;

    // Pending writes accumulate during the frame; active snapshot taken once per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    active_q[i] <= pending_q[i];
                end
            end
            if (cfg_valid && cfg_ready) begin
                pending_q[cfg_sel] <= {cfg_en, cfg_x, cfg_y, cfg_img};
            end
        end
    end

    // Lookahead pixel: LOOKAHEAD columns ahead, spilling onto the next line
    assign px_sum = {1'b0, hor_count} + 11'(LOOKAHEAD);

    // Wrap the lookahead column past the line end and advance the line (last line wraps to 0)
    always_comb begin
        px = px_sum;
        vy = {1'b0, ver_count};
        if (px_sum >= 11'(H_TOTAL)) begin
            px = px_sum - 11'(H_TOTAL);
            vy = (ver_count == 10'(V_TOTAL - 1)) ? 11'd0 : ({1'b0, ver_count} + 11'd1);
        end
    end

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
        sprite_hit_unit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_hit (
            .px      (px),
            .vy      (vy),
            .cfg     (active_q[g]),
            .hit     (hit_vec[g]),
            .col_off (col_off[g]),
            .row_off (row_off[g])
        );
    end

    // Priority encoder: scanning high to low lets the lowest hitting slot win; address holds on no hit
    always_comb begin
        hit_d      = 1'b0;
        rom_addr_d = rom_addr_q;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_d      = 1'b1;
                rom_addr_d = ADDR_W'({active_q[i].img, row_off[i], col_off[i]});
            end
        end
    end

    // Final stage: a transparent winner texel shows background, never a lower slot
    always_comb begin
        draw_d = s2_hit_q && (rom_data != TRANSPARENT);
        rgb_d  = draw_d ? rom_data : 6'd0;
    end

    // Pipeline: S1 address/hit, S2 hit aligned with ROM data, S3 pixel output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            s1_hit_q   <= 1'b0;
            s2_hit_q   <= 1'b0;
            draw_q     <= 1'b0;
            rgb_q      <= 6'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            s1_hit_q   <= hit_d;
            s2_hit_q   <= s1_hit_q;
            draw_q     <= draw_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign draw     = draw_q;
    assign rgb_out  = rgb_q;

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// tb/tb_sprite_pixel_scheduler.sv - directed scoreboard bench for sprite_pixel_scheduler
module tb_sprite_pixel_scheduler;
    import vga_sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hor_count = 10'd5;
    logic [9:0]  ver_count = 10'd11;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_sel = 2'd0;
    logic        cfg_en = 1'b0;
    logic [9:0]  cfg_x = 10'd0;
    logic [9:0]  cfg_y = 10'd0;
    logic [1:0]  cfg_img = 2'd0;
    logic [11:0] rom_addr;
    logic [5:0]  rom_data;
    logic        draw;
    logic [5:0]  rgb_out;
    logic        frame_tick;

    logic [5:0]  rom_mem [4096];

    sprite_cfg_t m_pend [4];
    sprite_cfg_t m_act  [4];
    int          m_addr;
    logic [6:0]  sb_q [$];

    int n_asserts = 0;
    int n_fail    = 0;

    sprite_pixel_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .hor_count  (hor_count),
        .ver_count  (ver_count),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_en     (cfg_en),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_img    (cfg_img),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .draw       (draw),
        .rgb_out    (rgb_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_pixel(input int h, input int v, output logic [6:0] pix, output bit hit, output int addr);
        int px;
        int vy;
        logic [5:0] t;
        px = h + 3;
        vy = v;
        if (px >= 800) begin
            px = px - 800;
            vy = (v == 524) ? 0 : v + 1;
        end
        hit  = 1'b0;
        pix  = 7'd0;
        addr = 0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && m_act[i].en && px < 640 && vy < 480 &&
                px >= int'(m_act[i].x) && px < int'(m_act[i].x) + 32 &&
                vy >= int'(m_act[i].y) && vy < int'(m_act[i].y) + 32) begin
                hit  = 1'b1;
                addr = int'(m_act[i].img) * 1024 + (vy - int'(m_act[i].y)) * 32 + (px - int'(m_act[i].x));
            end
        end
        if (hit) begin
            t = rom_mem[addr];
            if (t != 6'b110011) pix = {1'b1, t};
        end
    endtask

    task automatic step(input int h, input int v);
        logic [6:0] exp_pix;
        logic [6:0] e;
        bit         hit;
        int         addr;
        bit         commit_e;
        hor_count = 10'(h);
        ver_count = 10'(v);
        #1;
        commit_e = (h == 0 && v == 480);
        check("cfg_ready", 32'(cfg_ready), 32'(!commit_e));
        check("frame_tick", 32'(frame_tick), 32'(commit_e));
        model_pixel(h, v, exp_pix, hit, addr);
        if (hit) m_addr = addr;
        sb_q.push_back(exp_pix);
        @(posedge clk);
        if (commit_e) m_act = m_pend;
        if (cfg_valid && !commit_e) m_pend[cfg_sel] = {cfg_en, cfg_x, cfg_y, cfg_img};
        #1;
        e = sb_q.pop_front();
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("draw", 32'(draw), 32'(e[6]));
        check("rgb_out", 32'(rgb_out), 32'(e[5:0]));
    endtask

    task automatic run(input int v, input int h0, input int n);
        int h;
        int vv;
        for (int k = 0; k < n; k++) begin
            h  = h0 + k;
            vv = v;
            if (h >= 800) begin
                h  = h - 800;
                vv = (v + 1) % 525;
            end
            step(h, vv);
        end
    endtask

    task automatic cfg_write(input int sel, input int en, input int x, input int y, input int img,
                             input int h, input int v);
        cfg_valid = 1'b1;
        cfg_sel   = 2'(sel);
        cfg_en    = 1'(en);
        cfg_x     = 10'(x);
        cfg_y     = 10'(y);
        cfg_img   = 2'(img);
        step(h, v);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_draw", 32'(draw), 32'd0);
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = '0;
            m_act[i]  = '0;
        end
        m_addr = 0;
        sb_q.delete();
        sb_q.push_back(7'd0);
        sb_q.push_back(7'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) rom_mem[a] = 6'((a * 13 + 5) % 64);
        rom_mem[1189] = 6'b110011;
        rom_mem[2378] = 6'h0A;

        do_reset();

        // Slot 0 written on line 10; invisible until the commit
        cfg_write(0, 1, 100, 50, 1, 20, 10);
        run(50, 95, 40);
        step(0, 480);
        run(50, 92, 5);
        step(97, 50);
        check("slot0_first_addr", 32'(rom_addr), 32'd1024);
        run(50, 98, 40);
        run(51, 95, 40);

        // Overlap: slot 0 wins, its transparent texel does not fall through to slot 2
        cfg_write(0, 1, 200, 200, 1, 10, 100);
        cfg_write(2, 1, 195, 195, 2, 11, 100);
        step(0, 480);
        run(200, 190, 50);
        run(205, 190, 12);
        step(202, 205);
        check("overlap_addr", 32'(rom_addr), 32'd1189);
        run(205, 203, 30);

        // Clipping at the right and bottom edges of the active area
        cfg_write(0, 0, 0, 0, 0, 10, 200);
        cfg_write(2, 0, 0, 0, 0, 11, 200);
        cfg_write(1, 1, 620, 470, 2, 12, 200);
        step(0, 480);
        run(469, 615, 10);
        run(470, 610, 40);
        run(475, 610, 40);
        run(479, 610, 40);
        run(479, 795, 8);
        run(480, 610, 40);
        run(524, 795, 8);

        // cfg_valid held across the commit: blocked that cycle, next write lands in pending only
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        cfg_en    = 1'b1;
        cfg_x     = 10'd0;
        cfg_y     = 10'd11;
        cfg_img   = 2'd3;
        step(799, 479);
        cfg_en    = 1'b0;
        cfg_x     = 10'd300;
        step(0, 480);
        step(1, 480);
        cfg_valid = 1'b0;

        // Line wrap: lookahead crosses column 799 -> 0 onto line 11
        run(10, 790, 16);

        // Asynchronous reset mid-line while the sprite is drawing
        check("pre_reset_draw", 32'(draw), 32'd1);
        do_reset();
        run(11, 0, 40);
        step(0, 480);
        run(11, 0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
